// File: rtl/packet_frame_sequencer.sv
// Frames a latched payload as START_BYTE, payload[0..N-1], optional CRC-8 (FRAME_CRC_EN), END_BYTE.
// First byte one cycle after an accepted send; stalls while tx_ready is low; sends arriving mid-frame are dropped and counted.
`timescale 1ns/1ps
`ifndef PACKET_WIDTH
`define PACKET_WIDTH 6
`endif

module packet_frame_sequencer #(
    parameter logic [7:0] START_BYTE    = 8'h7E,
    parameter logic [7:0] END_BYTE      = 8'h81,
    parameter int         PAYLOAD_BYTES = `PACKET_WIDTH - 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PAYLOAD_BYTES-1:0][7:0] sys_packet,
    input  logic                          send,
    output logic [7:0]                    tx_byte,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          overrun,
    output logic [7:0]                    drop_count
);

    localparam int IDX_W = $clog2(PAYLOAD_BYTES) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_PAYLOAD,
`ifdef FRAME_CRC_EN
        S_CRC,
`endif
        S_END
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [PAYLOAD_BYTES-1:0][7:0]   r_shadow;
    logic [IDX_W-1:0]                r_idx;
    logic [IDX_W-1:0]                w_idx_nxt;
    logic                            r_frame_done;
    logic                            r_overrun;
    logic [7:0]                      r_drop_count;
    logic                            w_xfer;
    logic                            w_accept;
    logic                            w_drop;
    logic [7:0]                      w_payload_byte;
    logic [7:0]                      w_tx_byte;

`ifdef FRAME_CRC_EN
    logic [7:0] r_crc;
    logic [7:0] w_crc_nxt;

    // CRC-8, poly 0x07, MSB first, no reflection, no final XOR.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`endif

    // Outputs decode registered state only, so tx_valid/tx_byte have no path from send or tx_ready.
    assign tx_valid   = (r_state != S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign tx_byte    = w_tx_byte;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;
    assign drop_count = r_drop_count;
    assign w_xfer     = tx_valid && tx_ready;

    always_comb begin
        w_payload_byte = 8'h00;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_payload_byte = r_shadow[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_accept    = 1'b0;
        w_tx_byte   = 8'h00;
`ifdef FRAME_CRC_EN
        w_crc_nxt   = r_crc;
`endif
        case (r_state)
            S_IDLE: begin
                if (send) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_tx_byte = START_BYTE;
                if (w_xfer) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = S_PAYLOAD;
`ifdef FRAME_CRC_EN
                    w_crc_nxt   = 8'h00;
`endif
                end
            end
            S_PAYLOAD: begin
                w_tx_byte = w_payload_byte;
                if (w_xfer) begin
`ifdef FRAME_CRC_EN
                    w_crc_nxt = crc8_next(r_crc, w_payload_byte);
`endif
                    if (r_idx == LAST_IDX) begin
`ifdef FRAME_CRC_EN
                        w_state_nxt = S_CRC;
`else
                        w_state_nxt = S_END;
`endif
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
`ifdef FRAME_CRC_EN
            S_CRC: begin
                w_tx_byte = r_crc;
                if (w_xfer) begin
                    w_state_nxt = S_END;
                end
            end
`endif
            S_END: begin
                w_tx_byte = END_BYTE;
                if (w_xfer) begin
                    // A send coinciding with the final transfer chains straight into the next frame.
                    if (send) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_drop = send && !w_accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_shadow     <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_drop_count <= 8'h00;
`ifdef FRAME_CRC_EN
            r_crc        <= 8'h00;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_frame_done <= (r_state == S_END) && w_xfer;
            r_overrun    <= w_drop;
            if (w_accept) begin
                r_shadow <= sys_packet;
            end
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
`ifdef FRAME_CRC_EN
            r_crc        <= w_crc_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_packet_frame_sequencer.sv
// Directed bench for packet_frame_sequencer with PAYLOAD_BYTES=4; CRC expectations apply when FRAME_CRC_EN is defined.
`timescale 1ns/1ps

module tb_packet_frame_sequencer;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0][7:0] sys_packet;
    logic            send;
    logic [7:0]      tx_byte;
    logic            tx_valid;
    logic            tx_ready;
    logic            busy;
    logic            frame_done;
    logic            overrun;
    logic [7:0]      drop_count;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_b [8];
    int         exp_len;

    packet_frame_sequencer #(
        .START_BYTE   (8'h7E),
        .END_BYTE     (8'h81),
        .PAYLOAD_BYTES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sys_packet(sys_packet),
        .send      (send),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .frame_done(frame_done),
        .overrun   (overrun),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef FRAME_CRC_EN
    function automatic logic [7:0] model_crc(input logic [3:0][7:0] p);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 4; i++) begin
            c = c ^ p[i];
            for (int b = 0; b < 8; b++) begin
                c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
            end
        end
        return c;
    endfunction
`endif

    task automatic set_exp(input logic [3:0][7:0] p);
        exp_b[0] = 8'h7E;
        for (int i = 0; i < 4; i++) exp_b[1 + i] = p[i];
`ifdef FRAME_CRC_EN
        exp_b[5] = model_crc(p);
        exp_b[6] = 8'h81;
        exp_len  = 7;
`else
        exp_b[5] = 8'h81;
        exp_len  = 6;
`endif
    endtask

    task automatic start_frame(input logic [3:0][7:0] p);
        sys_packet = p;
        send       = 1'b1;
        tick();
        send       = 1'b0;
        sys_packet = 32'hDEADBEEF;
        check("busy_after_send", busy, 1'b1);
    endtask

    // Walks the frame in exp_b from the current START cycle. drop_at injects a
    // mid-frame send at byte k; chain injects a send with nxt during the END transfer.
    task automatic run_frame(input bit toggle, input int drop_at, input bit chain,
                             input logic [3:0][7:0] nxt);
        int  k;
        int  cyc;
        bit  dropped;
        k   = 0;
        cyc = 0;
        while (k < exp_len && cyc < 64) begin
            tx_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            check("tx_valid_in_frame", tx_valid, 1'b1);
            check("tx_byte_seq", tx_byte, exp_b[k]);
            dropped = 1'b0;
            if (k == drop_at) begin
                send       = 1'b1;
                sys_packet = 32'h55555555;
                dropped    = 1'b1;
            end
            if (chain && tx_ready && k == exp_len - 1) begin
                send       = 1'b1;
                sys_packet = nxt;
            end
            if (tx_ready) k++;
            cyc++;
            tick();
            send = 1'b0;
            check("overrun_pulse", overrun, dropped);
        end
        check("frame_completed", k, exp_len);
        check("frame_done_pulse", frame_done, 1'b1);
        if (chain) begin
            check("chain_tx_valid", tx_valid, 1'b1);
            check("chain_start_byte", tx_byte, 8'h7E);
        end else begin
            tx_ready = 1'b1;
            check("idle_after_frame", tx_valid, 1'b0);
            tick();
            check("frame_done_once", frame_done, 1'b0);
        end
    endtask

    initial begin
        reset      = 1'b1;
        send       = 1'b1;
        tx_ready   = 1'b1;
        sys_packet = 32'h12345678;
        tick();
        tick();
        reset = 1'b0;
        send  = 1'b0;
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_drop_count", drop_count, 8'h00);
        tick();
        check("send_with_reset_ignored", busy, 1'b0);

        // Basic frame, ready held high.
`ifdef FRAME_CRC_EN
        exp_b[0] = 8'h7E; exp_b[1] = 8'h01; exp_b[2] = 8'h02; exp_b[3] = 8'h03;
        exp_b[4] = 8'h04; exp_b[5] = 8'hE3; exp_b[6] = 8'h81; exp_len = 7;
`else
        set_exp({8'h04, 8'h03, 8'h02, 8'h01});
`endif
        start_frame({8'h04, 8'h03, 8'h02, 8'h01});
        run_frame(1'b0, -1, 1'b0, '0);

        // Same payload, ready toggling.
        set_exp({8'h04, 8'h03, 8'h02, 8'h01});
        start_frame({8'h04, 8'h03, 8'h02, 8'h01});
        run_frame(1'b1, -1, 1'b0, '0);

        // Second send two cycles after the first is dropped.
        start_frame({8'h04, 8'h03, 8'h02, 8'h01});
        run_frame(1'b0, 1, 1'b0, '0);
        check("drop_count_one", drop_count, 8'h01);

        // Many drops while stalled: count saturates, byte holds.
        set_exp({8'h44, 8'h33, 8'h22, 8'h11});
        start_frame({8'h44, 8'h33, 8'h22, 8'h11});
        tx_ready   = 1'b0;
        send       = 1'b1;
        sys_packet = 32'hFFFFFFFF;
        repeat (100) tick();
        check("drop_count_101", drop_count, 8'h65);
        repeat (200) tick();
        check("drop_count_sat", drop_count, 8'hFF);
        check("stall_hold_byte", tx_byte, 8'h7E);
        check("overrun_during_drops", overrun, 1'b1);
        send = 1'b0;
        tick();
        check("overrun_clears", overrun, 1'b0);
        check("drop_count_hold", drop_count, 8'hFF);
        run_frame(1'b0, -1, 1'b0, '0);

        // Back-to-back: send on the END transfer chains into a new frame.
        set_exp({8'h04, 8'h03, 8'h02, 8'h01});
        start_frame({8'h04, 8'h03, 8'h02, 8'h01});
        run_frame(1'b0, -1, 1'b1, {8'hDD, 8'hCC, 8'hBB, 8'hAA});
        check("chain_drop_count", drop_count, 8'hFF);
        set_exp({8'hDD, 8'hCC, 8'hBB, 8'hAA});
        run_frame(1'b0, -1, 1'b0, '0);

        // Reset mid-frame after the second payload byte.
        start_frame({8'h04, 8'h03, 8'h02, 8'h01});
        tick();
        tick();
        tick();
        check("pre_reset_byte", tx_byte, 8'h03);
        reset = 1'b1;
        send  = 1'b1;
        tick();
        reset = 1'b0;
        send  = 1'b0;
        check("midrst_tx_valid", tx_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_tx_byte", tx_byte, 8'h00);
        check("midrst_drop_count", drop_count, 8'h00);
        repeat (3) tick();
        check("no_resume", tx_valid, 1'b0);
        set_exp({8'h0D, 8'h0C, 8'h0B, 8'h0A});
        start_frame({8'h0D, 8'h0C, 8'h0B, 8'h0A});
        run_frame(1'b0, -1, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
